// File: rtl/bullet_scheduler.sv
// Bullet pool controller: fire request capture, slot allocation, per-frame motion and pixel hit output.
// Optional BULLET_AUTOFIRE_EN: a held fire button also raises requests every clock (level-triggered).
module bullet_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int BULL_SIZE = 4,
    parameter int BULL_V    = 3,
    parameter int SPAWN_Y   = 460,
    parameter int SPAWN_DX  = 3,
    parameter int TOP_Y     = 3,
    parameter int COOLDOWN  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic        fire,
    input  logic [10:0] player_x,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    output logic        bull_on,
    output logic [3:0]  active_cnt,
    output logic        fire_drop
);

    localparam logic [10:0] RETIRE_Y = 11'(TOP_Y + BULL_V);
    localparam logic [10:0] STEP_Y   = 11'(BULL_V);
    localparam logic [10:0] START_Y  = 11'(SPAWN_Y);
    localparam logic [10:0] OFFS_X   = 11'(SPAWN_DX);
    localparam logic [11:0] SPAN     = 12'(BULL_SIZE - 1);
    localparam logic [7:0]  CD_INIT  = 8'(COOLDOWN);

    function automatic logic [7:0] sat_dec(input logic [7:0] v);
        return (v == 8'd0) ? 8'd0 : v - 8'd1;
    endfunction

    function automatic logic [3:0] popcount(input logic [NUM_SLOTS-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < NUM_SLOTS; i++) n = n + {3'd0, v[i]};
        return n;
    endfunction

    logic        fire_p0, fire_p1, fire_p2;
    logic        sync_ok_p0, sync_ok_p1, armed;
    logic        fire_fall, req_set, drop_en;
    logic        pending;
    logic [7:0]  cd;

    logic [NUM_SLOTS-1:0] slot_vld, vld_nxt;
    logic [10:0]          slot_x [NUM_SLOTS];
    logic [10:0]          slot_y [NUM_SLOTS];
    logic                 any_free, spawn_ok;
    logic [2:0]           free_idx;

    // Stage p0/p1: synchronizer; p2: edge register. Edges are only honoured once a genuine
    // released level has passed the synchronizer, so a button held across reset stays silent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fire_p0    <= 1'b1;
            fire_p1    <= 1'b1;
            fire_p2    <= 1'b1;
            sync_ok_p0 <= 1'b0;
            sync_ok_p1 <= 1'b0;
            armed      <= 1'b0;
        end else begin
            fire_p0    <= fire;
            fire_p1    <= fire_p0;
            fire_p2    <= fire_p1;
            sync_ok_p0 <= 1'b1;
            sync_ok_p1 <= sync_ok_p0;
            if (sync_ok_p1 && fire_p1) armed <= 1'b1;
        end
    end

    assign fire_fall = armed & fire_p2 & ~fire_p1;

`ifdef BULLET_AUTOFIRE_EN
    logic pend_edge;

    assign req_set = fire_fall | ~fire_p1;
    assign drop_en = pend_edge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_edge <= 1'b0;
        end else if (frame_tick) begin
            pend_edge <= fire_fall;
        end else if (fire_fall) begin
            pend_edge <= 1'b1;
        end
    end
`else
    assign req_set = fire_fall;
    assign drop_en = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
        end else if (frame_tick) begin
            pending <= req_set;
        end else if (req_set) begin
            pending <= 1'b1;
        end
    end

    always_comb begin
        any_free = 1'b0;
        free_idx = 3'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_vld[i]) begin
                any_free = 1'b1;
                free_idx = 3'(i);
            end
        end
    end

    assign spawn_ok = pending && (cd == 8'd0) && any_free;

    always_comb begin
        vld_nxt = slot_vld;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (spawn_ok && free_idx == 3'(i))
                vld_nxt[i] = 1'b1;
            else if (slot_vld[i] && slot_y[i] < RETIRE_Y)
                vld_nxt[i] = 1'b0;
        end
    end

    // Frame update: spawn wins over motion for the chosen slot, retire check precedes subtraction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_vld   <= '0;
            active_cnt <= 4'd0;
            cd         <= 8'd0;
            fire_drop  <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_x[i] <= 11'd0;
                slot_y[i] <= 11'd0;
            end
        end else begin
            fire_drop <= frame_tick && pending && !spawn_ok && drop_en;
            if (frame_tick) begin
                slot_vld   <= vld_nxt;
                active_cnt <= popcount(vld_nxt);
                cd         <= spawn_ok ? CD_INIT : sat_dec(cd);
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (spawn_ok && free_idx == 3'(i)) begin
                        slot_x[i] <= player_x + OFFS_X;
                        slot_y[i] <= START_Y;
                    end else if (slot_vld[i] && slot_y[i] >= RETIRE_Y) begin
                        slot_y[i] <= slot_y[i] - STEP_Y;
                    end
                end
            end
        end
    end

    always_comb begin
        bull_on = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_vld[i]
                && {1'b0, pix_x} >= {1'b0, slot_x[i]} && {1'b0, pix_x} <= {1'b0, slot_x[i]} + SPAN
                && {1'b0, pix_y} >= {1'b0, slot_y[i]} && {1'b0, pix_y} <= {1'b0, slot_y[i]} + SPAN)
                bull_on = 1'b1;
        end
    end

endmodule

// File: tb/tb_bullet_scheduler.sv
// Scoreboard bench for bullet_scheduler (default parameters, BULLET_AUTOFIRE_EN undefined).
module tb_bullet_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_tick;
    logic        fire;
    logic [10:0] player_x;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        bull_on;
    logic [3:0]  active_cnt;
    logic        fire_drop;

    always #5 clk = ~clk;

    bullet_scheduler dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .fire       (fire),
        .player_x   (player_x),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .bull_on    (bull_on),
        .active_cnt (active_cnt),
        .fire_drop  (fire_drop)
    );

    // kind: 0 = bull_on at current pixel, 1 = active_cnt, 2 = fire_drop
    typedef struct {
        string tag;
        int    kind;
        int    exp;
    } chk_t;

    chk_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin : monitor
        chk_t c;
        int   act;
        while (sbq.size() > 0) begin
            c = sbq.pop_front();
            case (c.kind)
                0:       act = int'(bull_on);
                1:       act = int'(active_cnt);
                default: act = int'(fire_drop);
            endcase
            checks++;
            if (act != c.exp) begin
                errors++;
                $display("FAIL %s: actual %0d required %0d", c.tag, act, c.exp);
            end
        end
    end

    task automatic push(input string tag, input int kind, input int exp);
        chk_t c;
        c.tag  = tag;
        c.kind = kind;
        c.exp  = exp;
        sbq.push_back(c);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input int exp);
        push(tag, 1, exp);
    endtask

    task automatic check_drop(input string tag, input int exp);
        push(tag, 2, exp);
    endtask

    task automatic probe(input string tag, input int x, input int y, input int exp);
        pix_x = 11'(x);
        pix_y = 11'(y);
        push(tag, 0, exp);
        cyc(1);
    endtask

    task automatic press();
        fire = 1'b0;
        cyc(4);
        fire = 1'b1;
        cyc(3);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        fire    = 1'b1;
        cyc(2);
        reset_n = 1'b1;
        cyc(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        fire       = 1'b1;
        player_x   = 11'd315;
        pix_x      = 11'd0;
        pix_y      = 11'd0;

        // Reset state
        cyc(1);
        check_cnt("rst_cnt", 0);
        check_drop("rst_drop", 0);
        probe("rst_bull_origin", 0, 0, 0);
        reset_n = 1'b1;
        cyc(3);

        // Single fire at player_x=315 -> bullet at (318,460)
        press();
        tick();
        check_drop("spawn1_drop", 0);
        check_cnt("spawn1_cnt", 1);
        probe("spawn1_tl", 318, 460, 1);
        probe("spawn1_br", 321, 463, 1);
        probe("spawn1_right", 322, 460, 0);
        probe("spawn1_below", 318, 464, 0);
        probe("spawn1_left", 317, 460, 0);

        // Cooldown: second request one frame later is dropped, for one clock only
        press();
        tick();
        check_drop("cd_drop", 1);
        check_cnt("cd_cnt", 1);
        probe("cd_moved", 318, 457, 1);
        check_drop("cd_drop_1clk", 0);
        probe("cd_old_pos", 318, 461, 0);
        ticks(7);
        press();
        tick();
        check_drop("cd_expired_drop", 0);
        check_cnt("cd_expired_cnt", 2);
        probe("cd_slot0_y433", 318, 433, 1);
        probe("cd_slot0_above", 318, 432, 0);
        probe("cd_slot1_new", 318, 460, 1);

        // Pool full, flight to the wall, retire and reuse
        do_reset();
        for (int k = 0; k < 4; k++) begin
            press();
            tick();
            check_cnt("fill_cnt", k + 1);
            cyc(1);
            ticks(8);
        end
        press();
        tick();
        check_drop("full_drop", 1);
        check_cnt("full_cnt", 4);
        probe("full_no_spawn", 318, 460, 0);
        probe("full_slot3_y433", 318, 433, 1);
        ticks(116);
        probe("flight_y4", 318, 4, 1);
        probe("flight_y4_br", 321, 7, 1);
        probe("flight_y3", 318, 3, 0);
        press();
        tick();
        check_drop("retire_full_drop", 1);
        check_cnt("retire_cnt", 3);
        probe("retire_gone", 318, 4, 0);
        probe("retire_no_wrap", 318, 1, 0);
        probe("retire_no_spawn", 318, 460, 0);
        press();
        tick();
        check_drop("reuse_drop", 0);
        check_cnt("reuse_cnt", 4);
        probe("reuse_spawn", 318, 460, 1);

        // Asynchronous reset with three live bullets
        do_reset();
        for (int k = 0; k < 3; k++) begin
            press();
            tick();
            if (k < 2) ticks(8);
        end
        check_cnt("live3_cnt", 3);
        probe("live3_slot2", 318, 460, 1);
        probe("live3_slot1", 318, 433, 1);
        pix_x   = 11'd318;
        pix_y   = 11'd460;
        reset_n = 1'b0;
        fire    = 1'b0;
        #1;
        check_cnt("arst_cnt", 0);
        push("arst_bull", 0, 0);
        check_drop("arst_drop", 0);
        #5;
        reset_n = 1'b1;
        cyc(1);
        cyc(6);
        tick();
        check_cnt("held_no_req_cnt", 0);
        check_drop("held_no_req_drop", 0);
        probe("held_no_req_bull", 318, 460, 0);
        fire = 1'b1;
        cyc(3);
        player_x = 11'd100;
        press();
        tick();
        check_cnt("px100_cnt", 1);
        check_drop("px100_drop", 0);
        probe("px100_tl", 103, 460, 1);
        probe("px100_br", 106, 463, 1);
        probe("px100_left", 102, 460, 0);
        probe("px100_right", 107, 460, 0);

        cyc(2);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual %0d required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
